// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: CPU pushes bytes into a FIFO over the IO bus,
// and an FSM shifts them out on tx as 8N1 frames, LSB first, back-to-back.
module uart_tx_io #(
  parameter int BAUD_DIV   = 200,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic        uartcs,
  input  logic [1:0]  uartaddr,
  input  logic [15:0] uartwdata,
  output logic [15:0] uartrdata,
  output logic        tx
);

  localparam int PTR_W = CNT_W - 1;
  localparam int BC_W  = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;
  logic              push_ok;
  logic              clr_ovf;
  logic              pop;
  logic              bit_last;
  logic [7:0]        fifo_head;

  // Only the low byte of the write bus carries data.
  logic              unused_wdata;
  assign unused_wdata = ^uartwdata[15:8];

  // Bus handshake: a push is a single-cycle valid (cs & write & addr 0) with no
  // ready; a push that finds the FIFO full is dropped and latched as overflow.
  assign push_req   = uartcs & uartwrite & (uartaddr == 2'b00);
  assign clr_ovf    = uartcs & uartwrite & (uartaddr == 2'b10);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_ok    = push_req & ~fifo_full;
  assign bit_last   = (bit_cnt_q == BC_W'(BAUD_DIV - 1));
  assign fifo_head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            bit_idx_d = '0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= uartwdata[7:0];
    end
  end

  always_comb begin
    uartrdata = '0;
    if (uartcs && uartread && (uartaddr == 2'b10)) begin
      uartrdata[0]         = (state_q != S_IDLE);
      uartrdata[1]         = fifo_full;
      uartrdata[2]         = fifo_empty;
      uartrdata[3]         = ovf_q;
      uartrdata[4 +: CNT_W] = count_q;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: a queue-based model predicts tx and the status word every
// cycle; directed scenarios plus random bus traffic, with literal anchor values.
module tb_uart_tx_io;

  localparam int BAUD  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * BAUD;

  logic        clk;
  logic        rst;
  logic        uartwrite;
  logic        uartread;
  logic        uartcs;
  logic [1:0]  uartaddr;
  logic [15:0] uartwdata;
  logic [15:0] uartrdata;
  logic        tx;

  uart_tx_io #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uartwrite (uartwrite),
    .uartread  (uartread),
    .uartcs    (uartcs),
    .uartaddr  (uartaddr),
    .uartwdata (uartwdata),
    .uartrdata (uartrdata),
    .tx        (tx)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // behavioural model: pending bytes, and position within the frame on the wire
  logic [7:0] exp_q[$];
  logic [7:0] m_cur;
  bit         m_busy;
  int         m_pos;
  bit         m_ovf;
  bit         model_ok = 1'b0;
  int         m_pre;
  bit         m_full;
  bit         m_push;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy   = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_pre  = exp_q.size();
      m_full = (m_pre == DEPTH);
      m_push = uartcs && uartwrite && (uartaddr == 2'b00);
      if (uartcs && uartwrite && (uartaddr == 2'b10)) m_ovf = 1'b0;
      if (m_push && m_full) m_ovf = 1'b1;
      if (m_busy && m_pos != FRAME - 1) begin
        m_pos++;
      end else if (m_pre > 0) begin
        m_cur  = exp_q.pop_front();
        m_busy = 1'b1;
        m_pos  = 0;
      end else begin
        m_busy = 1'b0;
      end
      if (m_push && !m_full) exp_q.push_back(uartwdata[7:0]);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / BAUD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [15:0] exp_rdata();
    logic [15:0] s;
    s = '0;
    if (uartcs && uartread && (uartaddr == 2'b10)) begin
      s[0]   = m_busy;
      s[1]   = (exp_q.size() == DEPTH);
      s[2]   = (exp_q.size() == 0);
      s[3]   = m_ovf;
      s[8:4] = 5'(exp_q.size());
    end
    return s;
  endfunction

  // per-cycle compare, mid-cycle while inputs and outputs are stable
  always @(negedge clk) begin
    if (model_ok) begin
      check("tx", {15'b0, tx}, {15'b0, exp_tx()});
      check("rdata", uartrdata, exp_rdata());
    end
  end

  // driver tasks: each returns 1 time unit after a rising edge with the bus idle
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    uartcs    = 1'b0;
    uartwrite = 1'b0;
    uartread  = 1'b0;
    uartaddr  = 2'b00;
    uartwdata = 16'h0000;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    uartcs    = 1'b1;
    uartwrite = 1'b1;
    uartaddr  = a;
    uartwdata = d;
    cycle();
    bus_idle();
  endtask

  task automatic rd(input logic cs, input logic [1:0] a, output logic [15:0] v);
    uartcs   = cs;
    uartread = 1'b1;
    uartaddr = a;
    #2;
    v = uartrdata;
    cycle();
    bus_idle();
  endtask

  task automatic wait_idle(input int max_reads);
    logic [15:0] v;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_reads; i++) begin
      rd(1'b1, 2'b10, v);
      if (!v[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", {15'b0, ok}, 16'h0001);
  endtask

  task automatic wait_frame_pos(input int pos, input int need_cnt, input int max_cyc);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (m_busy && m_pos == pos && (need_cnt < 0 || exp_q.size() == need_cnt)) begin
        hit = 1'b1;
        break;
      end
      cycle();
    end
    check("frame_pos_wait", {15'b0, hit}, 16'h0001);
  endtask

  logic [15:0] v;
  logic [39:0] wave;
  int          lows;
  int          r;

  initial begin
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("reset_tx", {15'b0, tx}, 16'h0001);
    rd(1'b1, 2'b10, v);
    check("reset_status", v, 16'h0004);

    // single frame 0xA5: start, LSB-first data, stop, 4 cycles per bit
    wr(2'b00, 16'h00A5);
    wave = '0;
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      wave = {wave[38:0], tx};
    end
    check("a5_wave_hi", {8'h00, wave[39:32]}, 16'h000F);
    check("a5_wave_lo", wave[31:16], 16'b0000_1111_0000_0000);
    check("a5_wave_lo2", wave[15:0], 16'b1111_0000_1111_1111);
    cycle();
    cycle();
    rd(1'b1, 2'b10, v);
    check("a5_idle_status", v, 16'h0004);

    // back-to-back bytes: two still queued once the first frame starts
    wr(2'b00, 16'h0012);
    wr(2'b00, 16'h0034);
    wr(2'b00, 16'h0056);
    rd(1'b1, 2'b10, v);
    check("b2b_status", v, 16'h0021);
    wait_idle(300);

    // fill beyond capacity while the first frame is on the wire
    for (int i = 0; i < 18; i++) wr(2'b00, 16'($urandom_range(0, 255)) | 16'hAB00);
    rd(1'b1, 2'b10, v);
    check("full_ovf_status", v, 16'h010B);
    wr(2'b10, 16'h0000);
    rd(1'b1, 2'b10, v);
    check("ovf_cleared", v, 16'h0103);

    // push on the same edge the stop bit ends with 16 queued: rejected
    wait_frame_pos(FRAME - 1, DEPTH, 100);
    wr(2'b00, 16'h0077);
    rd(1'b1, 2'b10, v);
    check("pop_push_full", v, 16'h00F9);
    wr(2'b10, 16'h0000);
    wait_idle(1000);

    // reset in the middle of data bit 3 drops the frame and the queued byte
    wr(2'b00, 16'h003C);
    wr(2'b00, 16'h0099);
    wait_frame_pos(4 * BAUD + 1, -1, 100);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_tx", {15'b0, tx}, 16'h0001);
    rd(1'b1, 2'b10, v);
    check("rst_mid_status", v, 16'h0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    cycle();
    check("rst_no_frames", 16'(lows), 16'h0000);

    // reads that must return zero
    rd(1'b1, 2'b01, v);
    check("read_addr1", v, 16'h0000);
    rd(1'b0, 2'b10, v);
    check("read_nocs", v, 16'h0000);

    // random bus traffic, with an occasional reset
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      uartcs    = 1'b1;
      uartwrite = 1'b0;
      uartread  = 1'b0;
      uartaddr  = 2'($urandom_range(0, 3));
      uartwdata = 16'($urandom);
      if (r <= 2) begin
        uartwrite = 1'b1;
        uartaddr  = 2'b00;
      end else if (r == 3) begin
        uartwrite = 1'b1;
      end else if (r <= 6) begin
        uartread = 1'b1;
      end else if (r == 7) begin
        uartcs    = 1'b0;
        uartwrite = 1'b1;
        uartread  = 1'b1;
      end else begin
        uartcs = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cycle();
      bus_idle();
      rst = 1'b0;
    end
    wait_idle(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
